// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, bubble gating of control,
// and an optional skid slot that makes in_ready a pure flop output.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W  = 9,
  parameter int unsigned DATA_W  = 51,
  parameter int unsigned SKID_EN = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                in_ready_q, in_ready_d;
  logic                accept;
  logic                out_xfer;

  always_comb begin
    if (SKID_EN != 0) begin
      in_ready = in_ready_q;
    end else begin
      in_ready = ~RST & (out_ready | (state_q == StEmpty));
    end
  end

  assign out_valid = (state_q != StEmpty);
  assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
  assign out_data  = main_data_q;
  assign occupancy = state_q;

  assign accept   = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Payload registers are left alone so out_data keeps its last value.
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (accept && out_xfer) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept && (SKID_EN != 0)) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = StFull;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_xfer) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance and one single-entry instance, each checked
// against a queue-based FIFO model.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 9;
  localparam int unsigned DW = 51;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [CW-1:0] in_ctrl1, out_ctrl1;
  logic [DW-1:0] in_data1, out_data1;
  logic [1:0]    occ1;

  logic          flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [CW-1:0] in_ctrl0, out_ctrl0;
  logic [DW-1:0] in_data0, out_data0;
  logic [1:0]    occ0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1)) dut1 (
    .CLK(CLK), .RST(RST), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_ctrl(in_ctrl1), .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(0)) dut0 (
    .CLK(CLK), .RST(RST), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_ctrl(in_ctrl0), .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  // Model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  ent_t          q1[$];
  ent_t          q0[$];
  logic [DW-1:0] held1, held0;
  bit            rst_state1;
  int            n_tests, n_fail;

  function automatic logic exp_rdy1();
    return rst_state1 ? 1'b0 : (q1.size() < 2);
  endfunction

  function automatic logic exp_rdy0();
    return !RST && (q0.size() == 0 || out_ready0);
  endfunction

  function automatic logic [CW+DW+3:0] exp1();
    logic [CW-1:0] c;
    c = (q1.size() > 0) ? q1[0].c : '0;
    return {exp_rdy1(), q1.size() > 0, c, held1, 2'(q1.size())};
  endfunction

  function automatic logic [CW+DW+3:0] exp0();
    logic [CW-1:0] c;
    c = (q0.size() > 0) ? q0[0].c : '0;
    return {exp_rdy0(), q0.size() > 0, c, held0, 2'(q0.size())};
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  // Advance one clock edge and the model together; returns at the following negedge.
  task automatic step();
    logic acc1, acc0, xf1, xf0;
    ent_t e1, e0;
    acc1 = in_valid1 && exp_rdy1();
    xf1  = out_ready1 && (q1.size() > 0);
    acc0 = in_valid0 && exp_rdy0();
    xf0  = out_ready0 && (q0.size() > 0);
    e1   = {in_ctrl1, in_data1};
    e0   = {in_ctrl0, in_data0};
    @(posedge CLK);
    if (RST) begin
      q1.delete();
      q0.delete();
      held1      = '0;
      held0      = '0;
      rst_state1 = 1'b1;
    end else begin
      rst_state1 = 1'b0;
      if (flush1) q1.delete();
      else begin
        if (xf1) void'(q1.pop_front());
        if (acc1) q1.push_back(e1);
      end
      if (flush0) q0.delete();
      else begin
        if (xf0) void'(q0.pop_front());
        if (acc0) q0.push_back(e0);
      end
      if (q1.size() > 0) held1 = q1[0].d;
      if (q0.size() > 0) held0 = q0[0].d;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid1 = 1'b1; in_valid0 = 1'b1; out_ready1 = 1'b1; out_ready0 = 1'b1;
    in_data1 = rnd_data(); in_data0 = rnd_data(); in_ctrl1 = '1; in_ctrl0 = '1;
    step(); step(); #1;
    n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid1); end
    n_tests++; if (out_ctrl1 !== '0) begin n_fail++; $display("FAIL reset_out_ctrl got=%h want=0", out_ctrl1); end
    n_tests++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready1); end
    n_tests++; if ({occ1, out_data1} !== '0) begin n_fail++; $display("FAIL reset_occ_data got=%h/%h want=0", occ1, out_data1); end
    n_tests++; if ({in_ready0, out_valid0} !== 2'b00) begin n_fail++; $display("FAIL reset_noskid got=%b%b want=00", in_ready0, out_valid0); end
    RST = 1'b0; in_valid1 = 1'b0; in_valid0 = 1'b0;
    step(); #1;
    n_tests++; if ({in_ready1, in_ready0} !== 2'b11) begin n_fail++; $display("FAIL release_in_ready got=%b%b want=11", in_ready1, in_ready0); end
  endtask

  task automatic test_stream();
    logic [CW-1:0] ctl;
    out_ready1 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      ctl = CW'($urandom());
      in_valid1 = 1'b1; in_data1 = DW'(i); in_ctrl1 = ctl;
      step(); #1;
      n_tests++;
      if ({in_ready1, out_valid1, out_ctrl1, out_data1} !== {1'b1, 1'b1, ctl, DW'(i)}) begin
        n_fail++;
        $display("FAIL stream_%0d got=%b%b %h %h want=11 %h %h", i, in_ready1, out_valid1, out_ctrl1, out_data1, ctl, i);
      end
    end
    in_valid1 = 1'b0;
    step(); #1;
    n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL stream_drain got=%b want=0", out_valid1); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] a, b, c;
    a = rnd_data(); b = rnd_data(); c = rnd_data();
    out_ready1 = 1'b0; in_valid1 = 1'b1; in_ctrl1 = 9'h0A5;
    in_data1 = a; step();
    in_data1 = b; step();
    in_data1 = rnd_data(); step(); step(); #1;
    n_tests++;
    if ({occ1, in_ready1, out_valid1, out_data1} !== {2'd2, 1'b0, 1'b1, a}) begin
      n_fail++; $display("FAIL stall_hold got=%0d %b%b %h want=2 01 %h", occ1, in_ready1, out_valid1, out_data1, a);
    end
    out_ready1 = 1'b1; in_data1 = c; step(); #1;
    n_tests++; if (out_data1 !== b) begin n_fail++; $display("FAIL stall_second got=%h want=%h", out_data1, b); end
    step(); #1;
    n_tests++; if ({occ1, out_data1} !== {2'd1, c}) begin n_fail++; $display("FAIL stall_third got=%0d %h want=1 %h", occ1, out_data1, c); end
    in_valid1 = 1'b0; step(); #1;
    n_tests++; if (exp1() !== {in_ready1, out_valid1, out_ctrl1, out_data1, occ1}) begin n_fail++; $display("FAIL stall_end got=%h want=%h", {in_ready1, out_valid1, out_ctrl1, out_data1, occ1}, exp1()); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] a, d;
    a = rnd_data(); d = rnd_data();
    out_ready1 = 1'b0; in_valid1 = 1'b1; in_ctrl1 = 9'h1FF;
    in_data1 = a; step();
    in_data1 = rnd_data(); step(); #1;
    n_tests++; if (occ1 !== 2'd2) begin n_fail++; $display("FAIL flush_fill got=%0d want=2", occ1); end
    flush1 = 1'b1; in_data1 = rnd_data(); step();
    flush1 = 1'b0; in_valid1 = 1'b0; #1;
    n_tests++;
    if ({out_valid1, out_ctrl1, occ1, in_ready1, out_data1} !== {1'b0, 9'h0, 2'd0, 1'b1, a}) begin
      n_fail++; $display("FAIL flush_full got=%b %h %0d %b %h want=0 0 0 1 %h", out_valid1, out_ctrl1, occ1, in_ready1, out_data1, a);
    end
    // Flush while in_ready=1 so the same-cycle input would otherwise be taken.
    in_valid1 = 1'b1; in_data1 = d; step();
    flush1 = 1'b1; in_data1 = rnd_data(); step();
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1; #1;
    n_tests++; if ({out_valid1, out_data1} !== {1'b0, d}) begin n_fail++; $display("FAIL flush_one got=%b %h want=0 %h", out_valid1, out_data1, d); end
    step(); step(); #1;
    n_tests++; if ({out_valid1, occ1} !== 3'b000) begin n_fail++; $display("FAIL flush_dropped got=%b %0d want=0 0", out_valid1, occ1); end
  endtask

  task automatic test_bubble();
    int gaps;
    gaps = 0;
    out_ready1 = 1'b1; in_ctrl1 = 9'h1FF;
    for (int i = 0; i < 10; i++) begin
      in_valid1 = (i != 4); in_data1 = rnd_data();
      step(); #1;
      if (out_valid1 === 1'b0) begin
        gaps++;
        n_tests++; if (out_ctrl1 !== '0) begin n_fail++; $display("FAIL bubble_ctrl got=%h want=0", out_ctrl1); end
      end
    end
    n_tests++; if (gaps != 1) begin n_fail++; $display("FAIL bubble_count got=%0d want=1", gaps); end
    in_valid1 = 1'b0; step();
  endtask

  task automatic test_noskid();
    logic [DW-1:0] a, b;
    a = rnd_data(); b = rnd_data();
    out_ready0 = 1'b0; in_valid0 = 1'b1; in_ctrl0 = 9'h155; in_data0 = a;
    step(); in_data0 = rnd_data(); #1;
    n_tests++; if ({in_ready0, out_valid0, out_data0} !== {1'b0, 1'b1, a}) begin n_fail++; $display("FAIL noskid_full got=%b%b %h want=01 %h", in_ready0, out_valid0, out_data0, a); end
    step(); #1;
    n_tests++; if ({out_data0, occ0} !== {a, 2'd1}) begin n_fail++; $display("FAIL noskid_hold got=%h %0d want=%h 1", out_data0, occ0, a); end
    out_ready0 = 1'b1; in_data0 = b; #1;
    n_tests++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL noskid_ready got=%b want=1", in_ready0); end
    step(); #1;
    n_tests++; if ({out_valid0, out_data0, occ0} !== {1'b1, b, 2'd1}) begin n_fail++; $display("FAIL noskid_pass got=%b %h %0d want=1 %h 1", out_valid0, out_data0, occ0, b); end
    in_valid0 = 1'b0; step(); #1;
    n_tests++; if ({out_valid0, out_ctrl0, occ0} !== '0) begin n_fail++; $display("FAIL noskid_bubble got=%b %h %0d want=0", out_valid0, out_ctrl0, occ0); end
  endtask

  task automatic test_random();
    int fails_before;
    fails_before = n_fail;
    for (int i = 0; i < 3000; i++) begin
      RST        = ($urandom_range(0, 199) == 0);
      flush1     = ($urandom_range(0, 24) == 0);
      flush0     = ($urandom_range(0, 24) == 0);
      in_valid1  = $urandom_range(0, 1) == 1;
      in_valid0  = $urandom_range(0, 1) == 1;
      out_ready1 = $urandom_range(0, 9) < 7;
      out_ready0 = $urandom_range(0, 9) < 7;
      in_ctrl1 = CW'($urandom()); in_data1 = rnd_data();
      in_ctrl0 = CW'($urandom()); in_data0 = rnd_data();
      #1;
      if (n_fail - fails_before < 10) begin
        n_tests++;
        if ({in_ready1, out_valid1, out_ctrl1, out_data1, occ1} !== exp1()) begin
          n_fail++; $display("FAIL rand_skid cyc=%0d got=%h want=%h", i, {in_ready1, out_valid1, out_ctrl1, out_data1, occ1}, exp1());
        end
        n_tests++;
        if ({in_ready0, out_valid0, out_ctrl0, out_data0, occ0} !== exp0()) begin
          n_fail++; $display("FAIL rand_noskid cyc=%0d got=%h want=%h", i, {in_ready0, out_valid0, out_ctrl0, out_data0, occ0}, exp0());
        end
      end
      step();
    end
    RST = 1'b0; flush1 = 1'b0; flush0 = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    held1 = '0; held0 = '0; rst_state1 = 1'b1;
    RST = 1'b1; flush1 = 1'b0; flush0 = 1'b0;
    in_valid1 = 1'b0; in_valid0 = 1'b0; out_ready1 = 1'b0; out_ready0 = 1'b0;
    in_ctrl1 = '0; in_ctrl0 = '0; in_data1 = '0; in_data0 = '0;
    @(negedge CLK);
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
    test_noskid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
